// File: rtl/rst_btn_pkg.sv
// Shared types and 32.768 kHz default timings for the reset-button action classifier.
package rst_btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG,
    WARM,
    PWROFF,
    WAIT_REL,
    LOCKOUT
  } state_t;

  localparam int SHORT_MIN_CYC_DEF = 3277;    // ~100 ms
  localparam int LONG_CYC_DEF      = 262143;  // ~8 s
  localparam int PULSE_CYC_DEF     = 1024;
  localparam int LOCKOUT_CYC_DEF   = 16384;
  localparam int CNT_W_DEF         = 19;

endpackage

// File: rtl/rst_btn_action.sv
// Classifies the filtered reset-button hold time into warm reset or power-off.
// Define RST_BTN_PWROFF_EN to build the power-off request/acknowledge handshake.
module rst_btn_action
  import rst_btn_pkg::*;
#(
  parameter int SHORT_MIN_CYC = SHORT_MIN_CYC_DEF,
  parameter int LONG_CYC      = LONG_CYC_DEF,
  parameter int PULSE_CYC     = PULSE_CYC_DEF,
  parameter int LOCKOUT_CYC   = LOCKOUT_CYC_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic i_clk_32k,
  input  logic i_rst,
  input  logic i_rst_btn_press,
  input  logic i_pwr_off_ack,
  output logic o_warm_rst_req,
  output logic o_pwr_off_req,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(SHORT_MIN_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press_d;
  logic             from_long;
  logic             rise;

  assign rise = i_rst_btn_press & ~press_d;

`ifndef RST_BTN_PWROFF_EN
  logic unused_ack;
  assign unused_ack    = i_pwr_off_ack;
  assign o_pwr_off_req = 1'b0;
`endif

  // Outputs are registered copies of the current state, so they lag it by one edge.
  always_ff @(posedge i_clk_32k) begin
    if (i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      press_d        <= 1'b1;
      from_long      <= 1'b0;
      o_warm_rst_req <= 1'b0;
      o_busy         <= 1'b0;
`ifdef RST_BTN_PWROFF_EN
      o_pwr_off_req  <= 1'b0;
`endif
    end else begin
      press_d        <= i_rst_btn_press;
      o_busy         <= (state != IDLE);
      o_warm_rst_req <= (state == WARM);
`ifdef RST_BTN_PWROFF_EN
      o_pwr_off_req  <= (state == PWROFF);
`endif
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            cnt   <= CNT_W'(1);
          end
        end
        PRESSED: begin
          // Release is checked first so it wins over reaching the long threshold.
          if (!i_rst_btn_press) begin
            cnt   <= '0;
            state <= (cnt < SHORT_MIN) ? IDLE : WARM;
          end else if (cnt == LONG_LAST) begin
            cnt   <= '0;
            state <= LONG;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          cnt <= '0;
`ifdef RST_BTN_PWROFF_EN
          state <= PWROFF;
`else
          state     <= WAIT_REL;
          from_long <= 1'b1;
`endif
        end
        WARM: begin
          if (cnt == PULSE_LAST) begin
            cnt   <= '0;
            state <= LOCKOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef RST_BTN_PWROFF_EN
        PWROFF: begin
          if (i_pwr_off_ack) begin
            cnt   <= '0;
            state <= i_rst_btn_press ? WAIT_REL : LOCKOUT;
          end
        end
`endif
        WAIT_REL: begin
          if (!i_rst_btn_press) begin
            cnt       <= '0;
            from_long <= 1'b0;
            state     <= from_long ? WARM : LOCKOUT;
          end
        end
        LOCKOUT: begin
          if (cnt == LOCK_LAST) begin
            cnt   <= '0;
            state <= i_rst_btn_press ? WAIT_REL : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_btn_action.sv
// Directed bench for rst_btn_action with short test timings (4/16/3/8 cycles).
module tb_rst_btn_action;

  logic clk = 1'b0;
  logic rst, press, ack;
  logic warm, pwr, busy;

  always #5 clk = ~clk;

  rst_btn_action #(
    .SHORT_MIN_CYC(4),
    .LONG_CYC     (16),
    .PULSE_CYC    (3),
    .LOCKOUT_CYC  (8),
    .CNT_W        (19)
  ) dut (
    .i_clk_32k      (clk),
    .i_rst          (rst),
    .i_rst_btn_press(press),
    .i_pwr_off_ack  (ack),
    .o_warm_rst_req (warm),
    .o_pwr_off_req  (pwr),
    .o_busy         (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int warm_n, pwr_n, busy_n, warm_rise, pwr_rise, pwr_fall, both_n;
  logic warm_q = 1'b0, pwr_q = 1'b0;
  int k;

  always @(posedge clk) cyc <= cyc + 1;

  // Activity monitor: after the Nth rising edge, cyc == N at the following falling edge.
  always @(negedge clk) begin
    if (warm) warm_n++;
    if (pwr) pwr_n++;
    if (busy) busy_n++;
    if (warm && pwr) both_n++;
    if (warm && !warm_q && warm_rise < 0) warm_rise = cyc;
    if (pwr && !pwr_q && pwr_rise < 0) pwr_rise = cyc;
    if (!pwr && pwr_q && pwr_fall < 0) pwr_fall = cyc;
    warm_q = warm;
    pwr_q  = pwr;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    warm_n = 0; pwr_n = 0; busy_n = 0; both_n = 0;
    warm_rise = -1; pwr_rise = -1; pwr_fall = -1;
  endtask

  task automatic hold(input int h);
    press = 1'b1;
    tick(h);
    press = 1'b0;
  endtask

  initial begin
    rst = 1'b1; press = 1'b0; ack = 1'b0;
    clr();
    tick(3);
    chk("rst_warm", int'(warm), 0);
    chk("rst_pwr", int'(pwr), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(2);

    // 3-cycle press: rejected
    clr(); k = cyc + 1;
    hold(3);
    chk("short_busy_still_pressed", int'(busy), 1);
    tick(25);
    chk("short_busy_n", busy_n, 3);
    chk("short_warm_n", warm_n, 0);
    chk("short_pwr_n", pwr_n, 0);

    // 4-cycle press: warm pulse, then a press inside lockout is ignored
    clr(); k = cyc + 1;
    hold(4);
    tick(5);
    hold(3);
    tick(25);
    chk("min_warm_n", warm_n, 3);
    chk("min_warm_rise", warm_rise, k + 5);
    chk("min_busy_n", busy_n, 15);
    chk("min_pwr_n", pwr_n, 0);

    // 15-cycle press: release on the cycle the long threshold would be hit
    clr(); k = cyc + 1;
    hold(15);
    tick(30);
    chk("edge_warm_n", warm_n, 3);
    chk("edge_warm_rise", warm_rise, k + 16);
    chk("edge_pwr_n", pwr_n, 0);
    chk("edge_busy_n", busy_n, 26);

    // Long press held 40 cycles, ack pulse sampled at edge k+30
    clr(); k = cyc + 1;
    press = 1'b1;
    tick(30);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(9);
    press = 1'b0;
    tick(30);
`ifdef RST_BTN_PWROFF_EN
    chk("long_pwr_rise", pwr_rise, k + 17);
    chk("long_pwr_fall", pwr_fall, k + 31);
    chk("long_pwr_n", pwr_n, 14);
    chk("long_warm_n", warm_n, 0);
    chk("long_busy_n", busy_n, 48);
`else
    chk("long_pwr_n", pwr_n, 0);
    chk("long_warm_n", warm_n, 3);
    chk("long_warm_rise", warm_rise, k + 41);
    chk("long_busy_n", busy_n, 51);
`endif

    // Ack already high before a long press
    ack = 1'b1;
    clr(); k = cyc + 1;
    hold(20);
    tick(30);
    ack = 1'b0;
`ifdef RST_BTN_PWROFF_EN
    chk("preack_pwr_n", pwr_n, 1);
    chk("preack_pwr_rise", pwr_rise, k + 17);
    chk("preack_warm_n", warm_n, 0);
`else
    chk("preack_pwr_n", pwr_n, 0);
    chk("preack_warm_n", warm_n, 3);
    chk("preack_warm_rise", warm_rise, k + 21);
`endif

    // Button held across reset release: ignored until a fresh press
    press = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clr();
    tick(20);
    chk("held_busy_n", busy_n, 0);
    chk("held_warm_n", warm_n, 0);
    press = 1'b0;
    tick(3);

    // Reset asserted while the warm pulse is high
    clr(); k = cyc + 1;
    hold(4);
    tick(2);
    chk("midrst_warm_on", int'(warm), 1);
    rst = 1'b1;
    tick(1);
    chk("midrst_warm_off", int'(warm), 0);
    chk("midrst_busy_off", int'(busy), 0);
    rst = 1'b0;
    tick(20);
    chk("midrst_warm_n", warm_n, 1);
    chk("midrst_busy_n", busy_n, 5);

    chk("never_both", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
